// File: rtl/mf8_io_uart.sv
// mf8 IO-bus UART responder: 4-deep TX FIFO feeding a serial transmitter, a
// single-byte RX holding register behind a serial receiver, and a 16-bit divisor.
module mf8_io_uart #(
   parameter logic [5:0]  BASE_ADDR   = 6'h08,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       IO_Rd,
   input  logic       IO_Wr,
   input  logic [5:0] IO_Addr,
   input  logic [7:0] IO_WData,
   output logic [7:0] IO_RData,
   input  logic       RxD,
   output logic       TxD,
   output logic       Irq
);
   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

   // ---------------- register decode ----------------
   logic       sel;
   logic [1:0] reg_off;
   logic       data_wr, data_rd, status_rd, div_lo_wr, div_hi_wr;

   assign sel       = (IO_Addr[5:2] == BASE_ADDR[5:2]);
   assign reg_off   = IO_Addr[1:0];
   assign data_wr   = IO_Wr & sel & (reg_off == 2'd0);
   assign data_rd   = IO_Rd & sel & (reg_off == 2'd0);
   assign status_rd = IO_Rd & sel & (reg_off == 2'd1);
   assign div_lo_wr = IO_Wr & sel & (reg_off == 2'd2);
   assign div_hi_wr = IO_Wr & sel & (reg_off == 2'd3);

   // ---------------- divisor ----------------
   logic [15:0] div_reg;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         div_reg <= DEFAULT_DIV;
      end else begin
         if (div_lo_wr) div_reg[7:0]  <= IO_WData;
         if (div_hi_wr) div_reg[15:8] <= IO_WData;
      end
   end

   // ---------------- TX FIFO ----------------
   logic [7:0] fifo_mem_reg [4];
   logic [1:0] wr_ptr_reg, rd_ptr_reg;
   logic [2:0] count_reg;
   logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [7:0] fifo_head;

   assign fifo_full  = (count_reg == 3'd4);
   assign fifo_empty = (count_reg == 3'd0);
   assign fifo_push  = data_wr & ~fifo_full;
   assign fifo_head  = fifo_mem_reg[rd_ptr_reg];

   always_ff @(posedge Clk) begin
      if (fifo_push) fifo_mem_reg[wr_ptr_reg] <= IO_WData;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr_reg <= 2'd0;
         rd_ptr_reg <= 2'd0;
         count_reg  <= 3'd0;
      end else begin
         if (fifo_push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
         if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
         case ({fifo_push, fifo_pop})
            2'b10:   count_reg <= count_reg + 3'd1;
            2'b01:   count_reg <= count_reg - 3'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // ---------------- transmitter ----------------
   uart_state_t tx_state_reg;
   logic [15:0] tx_cnt_reg;
   logic [2:0]  tx_bit_reg;
   logic [7:0]  tx_shift_reg;
   logic        txd_reg;
   logic        tx_idle;

   // Popping straight out of STOP keeps back-to-back frames gap-free.
   assign fifo_pop = ~fifo_empty &
                     ((tx_state_reg == ST_IDLE) ||
                      ((tx_state_reg == ST_STOP) && (tx_cnt_reg == 16'd0)));
   assign tx_idle  = fifo_empty & (tx_state_reg == ST_IDLE);
   assign TxD      = txd_reg;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         tx_state_reg <= ST_IDLE;
         tx_cnt_reg   <= 16'd0;
         tx_bit_reg   <= 3'd0;
         tx_shift_reg <= 8'h00;
         txd_reg      <= 1'b1;
      end else begin
         case (tx_state_reg)
            ST_IDLE: begin
               if (fifo_pop) begin
                  tx_shift_reg <= fifo_head;
                  tx_cnt_reg   <= div_reg;
                  txd_reg      <= 1'b0;
                  tx_state_reg <= ST_START;
               end
            end
            ST_START: begin
               if (tx_cnt_reg != 16'd0) begin
                  tx_cnt_reg <= tx_cnt_reg - 16'd1;
               end else begin
                  tx_cnt_reg   <= div_reg;
                  tx_bit_reg   <= 3'd0;
                  txd_reg      <= tx_shift_reg[0];
                  tx_state_reg <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (tx_cnt_reg != 16'd0) begin
                  tx_cnt_reg <= tx_cnt_reg - 16'd1;
               end else begin
                  tx_cnt_reg <= div_reg;
                  if (tx_bit_reg == 3'd7) begin
                     txd_reg      <= 1'b1;
                     tx_state_reg <= ST_STOP;
                  end else begin
                     tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                     txd_reg      <= tx_shift_reg[1];
                     tx_bit_reg   <= tx_bit_reg + 3'd1;
                  end
               end
            end
            ST_STOP: begin
               if (tx_cnt_reg != 16'd0) begin
                  tx_cnt_reg <= tx_cnt_reg - 16'd1;
               end else if (fifo_pop) begin
                  tx_shift_reg <= fifo_head;
                  tx_cnt_reg   <= div_reg;
                  txd_reg      <= 1'b0;
                  tx_state_reg <= ST_START;
               end else begin
                  tx_state_reg <= ST_IDLE;
               end
            end
            default: tx_state_reg <= ST_IDLE;
         endcase
      end
   end

   // ---------------- receiver ----------------
   logic        rx_s1_reg, rx_s2_reg, rx_prev_reg;
   logic        rx_fall;
   uart_state_t rx_state_reg;
   logic [15:0] rx_cnt_reg;
   logic [2:0]  rx_bit_reg;
   logic [7:0]  rx_shift_reg;
   logic        stop_sample;
   logic [7:0]  rx_hold_reg;
   logic        rx_valid_reg, rx_ovr_reg, rx_fe_reg;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         rx_s1_reg   <= 1'b1;
         rx_s2_reg   <= 1'b1;
         rx_prev_reg <= 1'b1;
      end else begin
         rx_s1_reg   <= RxD;
         rx_s2_reg   <= rx_s1_reg;
         rx_prev_reg <= rx_s2_reg;
      end
   end

   assign rx_fall     = rx_prev_reg & ~rx_s2_reg;
   assign stop_sample = (rx_state_reg == ST_STOP) && (rx_cnt_reg == 16'd0);

   // Half a period into START lands every later sample mid-bit.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rx_state_reg <= ST_IDLE;
         rx_cnt_reg   <= 16'd0;
         rx_bit_reg   <= 3'd0;
         rx_shift_reg <= 8'h00;
      end else begin
         case (rx_state_reg)
            ST_IDLE: begin
               if (rx_fall) begin
                  rx_cnt_reg   <= div_reg >> 1;
                  rx_state_reg <= ST_START;
               end
            end
            ST_START: begin
               if (rx_cnt_reg != 16'd0) begin
                  rx_cnt_reg <= rx_cnt_reg - 16'd1;
               end else if (rx_s2_reg) begin
                  rx_state_reg <= ST_IDLE;
               end else begin
                  rx_cnt_reg   <= div_reg;
                  rx_bit_reg   <= 3'd0;
                  rx_state_reg <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (rx_cnt_reg != 16'd0) begin
                  rx_cnt_reg <= rx_cnt_reg - 16'd1;
               end else begin
                  rx_cnt_reg   <= div_reg;
                  rx_shift_reg <= {rx_s2_reg, rx_shift_reg[7:1]};
                  rx_bit_reg   <= rx_bit_reg + 3'd1;
                  if (rx_bit_reg == 3'd7) rx_state_reg <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (rx_cnt_reg != 16'd0) rx_cnt_reg <= rx_cnt_reg - 16'd1;
               else                     rx_state_reg <= ST_IDLE;
            end
            default: rx_state_reg <= ST_IDLE;
         endcase
      end
   end

   // Flag sets from a stop sample take priority over same-edge read clears.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rx_hold_reg  <= 8'h00;
         rx_valid_reg <= 1'b0;
         rx_ovr_reg   <= 1'b0;
         rx_fe_reg    <= 1'b0;
      end else begin
         if (data_rd && rx_valid_reg) begin
            rx_valid_reg <= 1'b0;
            rx_fe_reg    <= 1'b0;
         end
         if (status_rd) rx_ovr_reg <= 1'b0;
         if (stop_sample) begin
            if (!rx_s2_reg) begin
               rx_fe_reg <= 1'b1;
            end else if (!rx_valid_reg || data_rd) begin
               rx_hold_reg  <= rx_shift_reg;
               rx_valid_reg <= 1'b1;
            end else begin
               rx_ovr_reg <= 1'b1;
            end
         end
      end
   end

   assign Irq = rx_valid_reg;

   // ---------------- read mux ----------------
   always_comb begin
      IO_RData = 8'h00;
      if (sel) begin
         case (reg_off)
            2'd0:    IO_RData = rx_hold_reg;
            2'd1:    IO_RData = {3'b000, rx_fe_reg, rx_ovr_reg, rx_valid_reg,
                                 tx_idle, ~fifo_full};
            2'd2:    IO_RData = div_reg[7:0];
            default: IO_RData = div_reg[15:8];
         endcase
      end
   end
endmodule

// File: tb/tb_mf8_io_uart.sv
// Directed self-checking bench for mf8_io_uart: register access, TX waveform,
// FIFO overflow, RX receive/overrun/framing/false start, decode and reset.
module tb_mf8_io_uart;
   localparam logic [5:0] A_DATA = 6'h08;
   localparam logic [5:0] A_STAT = 6'h09;
   localparam logic [5:0] A_DLO  = 6'h0A;
   localparam logic [5:0] A_DHI  = 6'h0B;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       IO_Rd = 1'b0;
   logic       IO_Wr = 1'b0;
   logic [5:0] IO_Addr = 6'h00;
   logic [7:0] IO_WData = 8'h00;
   logic [7:0] IO_RData;
   logic       RxD = 1'b1;
   logic       TxD;
   logic       Irq;

   int n_checks = 0;
   int n_pass = 0;
   int errs;
   int fifo_errs;
   logic fifo_found;
   logic [7:0] rd_val;
   logic [7:0] fifo_bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

   always #5 Clk = ~Clk;

   mf8_io_uart #(.BASE_ADDR(6'h08), .DEFAULT_DIV(16'd433)) dut (
      .Clk(Clk), .Reset(Reset), .IO_Rd(IO_Rd), .IO_Wr(IO_Wr),
      .IO_Addr(IO_Addr), .IO_WData(IO_WData), .IO_RData(IO_RData),
      .RxD(RxD), .TxD(TxD), .Irq(Irq)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("ok   %s = %0h", tag, got);
      end else begin
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // All bus tasks start and end 1 time unit after a rising edge.
   task automatic io_write(input logic [5:0] a, input logic [7:0] d);
      IO_Wr = 1'b1; IO_Addr = a; IO_WData = d;
      @(posedge Clk); #1;
      IO_Wr = 1'b0;
   endtask

   task automatic io_read(input logic [5:0] a, output logic [7:0] d);
      IO_Rd = 1'b1; IO_Addr = a;
      #2 d = IO_RData;
      @(posedge Clk); #1;
      IO_Rd = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [5:0] a, input logic [7:0] exp);
      logic [7:0] d;
      io_read(a, d);
      check(tag, {24'h0, d}, {24'h0, exp});
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   // Serial frame at 8 cycles per bit (DIV=7).
   task automatic uart_send(input logic [7:0] b, input logic stop_bit);
      RxD = 1'b0;
      wait_cycles(8);
      for (int i = 0; i < 8; i++) begin
         RxD = b[i];
         wait_cycles(8);
      end
      RxD = stop_bit;
      wait_cycles(8);
      RxD = 1'b1;
   endtask

   function automatic logic exp_tx(input logic [7:0] b, input int c, input int p);
      int k;
      k = c / p;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      return 1'b1;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // reset state
      wait_cycles(2);
      Reset = 1'b0;
      check("rst_txd", TxD, 1);
      check("rst_irq", Irq, 0);
      read_check("rst_status", A_STAT, 8'h03);
      read_check("rst_div_lo", A_DLO, 8'hB1);
      read_check("rst_div_hi", A_DHI, 8'h01);

      // single transmit, DIV=3
      io_write(A_DLO, 8'h03);
      io_write(A_DHI, 8'h00);
      io_write(A_DATA, 8'hA5);
      check("tx_pre_txd", TxD, 1);
      read_check("tx_busy_st", A_STAT, 8'h01);
      errs = 0;
      for (int i = 0; i < 40; i++) begin
         if (i > 0) wait_cycles(1);
         if (TxD !== exp_tx(8'hA5, i, 4)) errs++;
      end
      check("tx_a5_wave", errs, 0);
      read_check("tx_last_st", A_STAT, 8'h01);
      read_check("tx_done_st", A_STAT, 8'h03);

      // FIFO full: 0x11 in flight, then five writes; the fifth is dropped
      io_write(A_DATA, fifo_bytes[0]);
      fork
         begin
            fifo_found = 1'b0;
            for (int i = 0; i < 50 && !fifo_found; i++) begin
               @(negedge Clk);
               if (TxD == 1'b0) fifo_found = 1'b1;
            end
            check("fifo_start", fifo_found, 1);
            fifo_errs = 0;
            if (fifo_found) begin
               for (int j = 0; j < 210; j++) begin
                  if (j > 0) @(negedge Clk);
                  if (j < 200) begin
                     if (TxD !== exp_tx(fifo_bytes[j/40], j % 40, 4)) fifo_errs++;
                  end else if (TxD !== 1'b1) begin
                     fifo_errs++;
                  end
               end
            end
            check("fifo_frames", fifo_errs, 0);
         end
         begin
            wait_cycles(1);
            for (int i = 1; i < 5; i++) io_write(A_DATA, fifo_bytes[i]);
            io_write(A_DATA, 8'h66);
            read_check("fifo_full_st", A_STAT, 8'h00);
         end
      join
      wait_cycles(1);
      read_check("fifo_idle_st", A_STAT, 8'h03);

      // receive, DIV=7
      io_write(A_DLO, 8'h07);
      uart_send(8'h3C, 1'b1);
      check("rx_irq", Irq, 1);
      read_check("rx_status", A_STAT, 8'h07);
      read_check("rx_data", A_DATA, 8'h3C);
      check("rx_irq_clr", Irq, 0);
      read_check("rx_clr_st", A_STAT, 8'h03);

      // overrun
      uart_send(8'hA1, 1'b1);
      uart_send(8'h5E, 1'b1);
      read_check("ovr_status", A_STAT, 8'h0F);
      read_check("ovr_clr_st", A_STAT, 8'h07);
      read_check("ovr_data", A_DATA, 8'hA1);
      read_check("ovr_end_st", A_STAT, 8'h03);

      // framing error persists until a valid byte is read
      uart_send(8'h55, 1'b0);
      read_check("fe_status", A_STAT, 8'h13);
      check("fe_irq", Irq, 0);
      uart_send(8'h96, 1'b1);
      read_check("fe_valid_st", A_STAT, 8'h17);
      read_check("fe_data", A_DATA, 8'h96);
      read_check("fe_clr_st", A_STAT, 8'h03);

      // false start: 2-cycle glitch
      RxD = 1'b0;
      wait_cycles(2);
      RxD = 1'b1;
      wait_cycles(20);
      read_check("glitch_st", A_STAT, 8'h03);
      check("glitch_irq", Irq, 0);
      uart_send(8'h42, 1'b1);
      read_check("glitch_data", A_DATA, 8'h42);

      // decode window
      read_check("dec_rd_c", 6'h0C, 8'h00);
      read_check("dec_rd_d", 6'h0D, 8'h00);
      io_write(6'h0E, 8'h55);
      io_write(6'h0C, 8'h77);
      read_check("dec_status", A_STAT, 8'h03);
      read_check("dec_div_lo", A_DLO, 8'h07);

      // reset in the middle of a frame
      io_write(A_DATA, 8'h00);
      io_write(A_DATA, 8'hFF);
      wait_cycles(10);
      check("mid_txd_low", TxD, 0);
      Reset = 1'b1;
      wait_cycles(1);
      check("mid_rst_txd", TxD, 1);
      Reset = 1'b0;
      errs = 0;
      for (int i = 0; i < 12; i++) begin
         wait_cycles(1);
         if (TxD !== 1'b1) errs++;
      end
      check("mid_txd_idle", errs, 0);
      read_check("mid_status", A_STAT, 8'h03);
      read_check("mid_div_lo", A_DLO, 8'hB1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mf8_io_uart.md
# mf8_io_uart

IO-bus responder that hangs off the mf8 core's 6-bit IO port (`IO_Rd`/`IO_Wr`/`IO_Addr`/`IO_WData`/`IO_RData`) and exposes a UART to firmware.

- Contains a 4-entry transmit FIFO, a serial transmitter, a single-byte receive holding register with a serial receiver, and a programmable 16-bit bit-period divisor.
- It is the target end of the core's `IN`/`OUT` accesses.
- Its read data is ORed with other peripherals onto `IO_RData`.

## Interface

Parameters:
- `BASE_ADDR`, default 6'h08: IO address of register 0. Must be 4-aligned; the block occupies `BASE_ADDR`..`BASE_ADDR+3`.
- `DEFAULT_DIV`, default 16'd433: reset value of the divisor. Bit period = DIV+1 Clk cycles.

Ports:
- `Clk`  in  1: clock, all state on rising edge.
- `Reset`  in  1: synchronous, active-high.
- `IO_Rd`  in  1: read strobe, one cycle per access.
- `IO_Wr`  in  1: write strobe, one cycle per access.
- `IO_Addr`  in  6: register address, valid while a strobe is high.
- `IO_WData`  in  8: write data, valid while `IO_Wr` is high.
- `IO_RData`  out  8: combinational read data. 8'h00 when `IO_Addr` is outside this block's window.
- `RxD`  in  1: asynchronous serial input, idle high.
- `TxD`  out  1: serial output, idle high.
- `Irq`  out  1: registered; equals RX valid.

## Operation

Register map (offset = `IO_Addr` − `BASE_ADDR`):
- **0 DATA**
  - Write pushes `IO_WData` into the TX FIFO.
  - Read returns the RX holding register.
  - Read with RX valid=1 clears valid and framing error (FE).
- **1 STATUS** (read-only; writes ignored)
  - bit0 TXRDY: FIFO not full.
  - bit1 TXIDLE: FIFO empty and transmitter idle.
  - bit2 RXVALID.
  - bit3 OVR.
  - bit4 FE.
  - bits 7:5 read 0.
  - A read clears OVR.
- **2 DIV_LO**, **3 DIV_HI**: read/write the divisor bytes.

Decode:
- Matches when `IO_Addr[5:2]` == `BASE_ADDR[5:2]`.
- `IO_RData` is selected from `IO_Addr` regardless of `IO_Rd`.
- Side effects (pop, flag clears) happen only on the edge where `IO_Rd`=1.

TX FIFO:
- Depth 4, 2-bit pointers plus count.
- Write when full: byte dropped, no state change.
- A push and a pop on the same edge are both performed; count unchanged.

Transmitter FSM: `IDLE` → `START` → `DATA` (8 bits, LSB first) → `STOP` → `IDLE`/`START`.
- In `IDLE` with FIFO non-empty: pop into the shift register, go to `START`.
- In `STOP` at end of period with FIFO non-empty: pop directly into `START`, with no extra idle cycle.
- Each state bit lasts exactly DIV+1 cycles, counted by a down-counter reloaded from DIV at each bit boundary.
- A DIV write mid-frame takes effect at the next reload.

Receiver:
- `RxD` passes through a 2-flop synchroniser.
- FSM: `IDLE` → `START` → `DATA` → `STOP`.
- `IDLE`: a synchronised 1→0 transition enters `START` and loads the counter with DIV>>1.
- `START`: at counter expiry, if the line is high, return to `IDLE` (false start). Otherwise load DIV and go to `DATA`.
- `DATA`: sample 8 bits at DIV+1 spacing, LSB first.
- `STOP` sample:
  - 1 with valid=0: store the byte, set valid.
  - 1 with valid=1 and no DATA read on the same edge: set OVR, keep the old byte, discard the new one.
  - 1 with valid=1 and a DATA read on the same edge: store the new byte, valid stays 1, OVR unchanged.
  - 0: set FE, discard the byte.
- In all cases return to `IDLE`.
- RX correctness requires DIV ≥ 3. TX works for any DIV.

Reset values:
- `TxD`=1, `Irq`=0.
- Both FSMs `IDLE`, FIFO empty.
- valid/OVR/FE = 0, holding register 8'h00.
- DIV = `DEFAULT_DIV`, synchroniser flops = 1.
- `IO_RData` follows the reset register contents (STATUS reads 8'h03).
- Reset mid-frame: `TxD` returns high on the next edge and the partial frame is lost.

## Timing

- Write in cycle k: entry visible in the FIFO after edge k, TXRDY/TXIDLE update after edge k. From an idle transmitter, the pop occurs at edge k+1, and `TxD` goes low after edge k+1.
- One frame = 10×(DIV+1) cycles. Back-to-back frames are continuous.
- Read data is same-cycle combinational. Flag clears/pops are visible from the cycle after the `IO_Rd` cycle.
- RX byte: valid and `Irq` rise on the edge after the stop-bit sample, which occurs about 9.5 bit periods plus 2 synchroniser cycles after the start edge.

## Test plan

- **Reset state:** assert `Reset` 2 cycles, read STATUS → 8'h03; `TxD`=1, `Irq`=0; DIV_LO/HI read back `DEFAULT_DIV`.
- **Single transmit:** DIV=3, write 8'hA5 → `TxD` goes low after edge k+1, then bits 1,0,1,0,0,1,0,1, then 1, each 4 cycles; TXIDLE=1 after 40 cycles.
- **FIFO full:** write 5 bytes in consecutive cycles with the transmitter busy → TXRDY=0 after 4 entries; the 5th is dropped; exactly 4 frames emitted back-to-back with no gap.
- **Receive, then overrun:** DIV=7, drive 8'h3C at 8-cycle bits → `Irq`=1, DATA reads 8'h3C. Drive two bytes with no read → OVR=1, first byte retained; STATUS read clears OVR.
- **Framing error and false start:**
  - Stop bit 0 → FE=1, RXVALID=0.
  - 2-cycle low glitch with DIV=7 → FSM returns to `IDLE`, no flags set.
- **Decode and mid-frame reset:**
  - Access `BASE_ADDR+4` → `IO_RData`=8'h00, no side effects.
  - `Reset` mid-frame → `TxD`=1 the next cycle, FIFO empty.
